// File: rtl/mem_sram_ctrl_pkg.sv
// Shared types and defaults for the MEM-stage SRAM sequencer.
// The sequencer splits each 32-bit access into two 16-bit half-word phases.
package mem_sram_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LO,
      ST_HI,
      ST_DONE
   } state_e;

   localparam int unsigned DEF_BASE_ADDR   = 1024;
   localparam int unsigned DEF_HALF_CYCLES = 2;
   localparam int unsigned DEF_SRAM_AW     = 18;
   localparam int unsigned SRAM_DW         = 16;
   localparam int unsigned CNT_W           = 4;

endpackage

// File: rtl/mem_sram_ctrl_if.sv
// Pipeline request/response and SRAM pin bundle for the sequencer.
// The slave side is the controller; the master side is pipeline plus SRAM.
interface mem_sram_ctrl_if
   import mem_sram_ctrl_pkg::*;
#(
   parameter int unsigned SRAM_AW = DEF_SRAM_AW
);

   logic                rd_en;
   logic                wr_en;
   logic [31:0]         address;
   logic [31:0]         write_data;
   logic [31:0]         read_data;
   logic                ready;

   logic [SRAM_AW-1:0]  sram_addr;
   logic [SRAM_DW-1:0]  sram_dq_out;
   logic                sram_dq_oe;
   logic [SRAM_DW-1:0]  sram_dq_in;
   logic                sram_we_n;
   logic                sram_oe_n;
   logic                sram_ce_n;
   logic                sram_ub_n;
   logic                sram_lb_n;

   modport slave (
      input  rd_en, wr_en, address, write_data, sram_dq_in,
      output read_data, ready,
      output sram_addr, sram_dq_out, sram_dq_oe,
      output sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n
   );

   modport master (
      output rd_en, wr_en, address, write_data, sram_dq_in,
      input  read_data, ready,
      input  sram_addr, sram_dq_out, sram_dq_oe,
      input  sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n
   );

endinterface

// File: rtl/mem_sram_ctrl.sv
// MEM-stage data memory sequencer: one 32-bit load/store becomes two 16-bit
// asynchronous SRAM phases (LO then HI); ready stays low until DONE.
module mem_sram_ctrl
   import mem_sram_ctrl_pkg::*;
#(
   parameter int unsigned BASE_ADDR   = DEF_BASE_ADDR,
   parameter int unsigned HALF_CYCLES = DEF_HALF_CYCLES,
   parameter int unsigned SRAM_AW     = DEF_SRAM_AW
) (
   input  logic           clk,
   input  logic           rst,
   mem_sram_ctrl_if.slave bus
);

   localparam int unsigned       WORD_W   = SRAM_AW - 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(HALF_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                wr_q, wr_d;
   logic [WORD_W-1:0]   word_q, word_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [31:0]         rdata_q, rdata_d;

   logic [31:0]         offset;
   logic                unused_offset_bits;
   logic                phase_last;
   logic                in_hi;

   logic                ready;
   logic [SRAM_AW-1:0]  sram_addr;
   logic [SRAM_DW-1:0]  sram_dq_out;
   logic                sram_dq_oe;
   logic                sram_we_n;
   logic                sram_oe_n;
   logic                sram_ce_n;
   logic                sram_ub_n;
   logic                sram_lb_n;

   // Out-of-range addresses simply wrap into the SRAM word space.
   assign offset             = bus.address - BASE_ADDR;
   assign unused_offset_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};

   assign phase_last = (cnt_q == CNT_LAST);
   assign in_hi      = (state_q == ST_HI);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         word_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         word_q  <= word_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      wr_d        = wr_q;
      word_d      = word_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;

      ready       = 1'b0;
      sram_addr   = '0;
      sram_dq_out = '0;
      sram_dq_oe  = 1'b0;
      sram_we_n   = 1'b1;
      sram_oe_n   = 1'b1;
      sram_ce_n   = 1'b1;
      sram_ub_n   = 1'b1;
      sram_lb_n   = 1'b1;

      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (bus.rd_en || bus.wr_en) begin
               // A simultaneous read and write request resolves as a write.
               wr_d    = bus.wr_en;
               word_d  = offset[SRAM_AW:2];
               wdata_d = bus.write_data;
               state_d = ST_LO;
            end else begin
               ready = 1'b1;
            end
         end

         ST_LO, ST_HI: begin
            sram_ce_n = 1'b0;
            sram_ub_n = 1'b0;
            sram_lb_n = 1'b0;
            sram_addr = {word_q, in_hi};

            if (wr_q) begin
               sram_dq_oe  = 1'b1;
               sram_dq_out = in_hi ? wdata_q[31:16] : wdata_q[15:0];
               // we_n rises one cycle early so address/data hold past the strobe.
               sram_we_n   = phase_last;
            end else begin
               sram_oe_n = 1'b0;
               if (phase_last) begin
                  if (in_hi) rdata_d[31:16] = bus.sram_dq_in;
                  else       rdata_d[15:0]  = bus.sram_dq_in;
               end
            end

            if (phase_last) begin
               cnt_d   = '0;
               state_d = in_hi ? ST_DONE : ST_HI;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         ST_DONE: begin
            ready   = 1'b1;
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign bus.ready       = ready;
   assign bus.read_data   = rdata_q;
   assign bus.sram_addr   = sram_addr;
   assign bus.sram_dq_out = sram_dq_out;
   assign bus.sram_dq_oe  = sram_dq_oe;
   assign bus.sram_we_n   = sram_we_n;
   assign bus.sram_oe_n   = sram_oe_n;
   assign bus.sram_ce_n   = sram_ce_n;
   assign bus.sram_ub_n   = sram_ub_n;
   assign bus.sram_lb_n   = sram_lb_n;

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Directed bench for mem_sram_ctrl with a small behavioural 16-bit SRAM.
// Expected values are hand-computed for BASE_ADDR=1024, HALF_CYCLES=2.
module sram_model #(
   parameter int unsigned AW         = 18,
   parameter int unsigned DEPTH_LOG2 = 6
) (
   input  logic          clk,
   input  logic [AW-1:0] addr,
   input  logic [15:0]   dq_w,
   input  logic          dq_oe,
   input  logic          we_n,
   input  logic          oe_n,
   input  logic          ce_n,
   input  logic          ub_n,
   input  logic          lb_n,
   output logic [15:0]   dq_r
);
   logic [15:0]           mem [1 << DEPTH_LOG2];
   logic [DEPTH_LOG2-1:0] idx;
   logic                  unused_addr_hi;

   assign idx            = addr[DEPTH_LOG2-1:0];
   assign unused_addr_hi = ^addr[AW-1:DEPTH_LOG2];

   initial begin
      for (int i = 0; i < (1 << DEPTH_LOG2); i++) mem[i] = 16'h0000;
   end

   // Data is taken while we_n is low, i.e. stable before the strobe rises.
   always @(posedge clk) begin
      if (!ce_n && !we_n && dq_oe) begin
         if (!lb_n) mem[idx][7:0]  <= dq_w[7:0];
         if (!ub_n) mem[idx][15:8] <= dq_w[15:8];
      end
   end

   assign dq_r = (!ce_n && !oe_n && !dq_oe) ? mem[idx] : 16'hFFFF;
endmodule

module tb_mem_sram_ctrl;
   import mem_sram_ctrl_pkg::*;

   localparam int unsigned AW = 18;

   logic clk = 1'b0;
   logic rst;

   int n_checks = 0;
   int n_errors = 0;

   logic [AW-1:0] seen_addr [16];
   logic [15:0]   seen_dq   [16];

   mem_sram_ctrl_if #(.SRAM_AW(AW)) bus ();

   mem_sram_ctrl #(
      .BASE_ADDR  (1024),
      .HALF_CYCLES(2),
      .SRAM_AW    (AW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   sram_model #(
      .AW        (AW),
      .DEPTH_LOG2(6)
   ) u_sram (
      .clk  (clk),
      .addr (bus.sram_addr),
      .dq_w (bus.sram_dq_out),
      .dq_oe(bus.sram_dq_oe),
      .we_n (bus.sram_we_n),
      .oe_n (bus.sram_oe_n),
      .ce_n (bus.sram_ce_n),
      .ub_n (bus.sram_ub_n),
      .lb_n (bus.sram_lb_n),
      .dq_r (bus.sram_dq_in)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic go_idle();
      bus.rd_en = 1'b0;
      bus.wr_en = 1'b0;
      tick();
   endtask

   // Issues a request in the current IDLE cycle and steps until ready returns;
   // ends sampling the DONE cycle. ncyc counts the request cycle through DONE.
   task automatic run_access(input string tag, input logic wr, input logic rd,
                             input logic [31:0] a, input logic [31:0] d,
                             output int ncyc, output logic [15:0] we_mask,
                             output logic [15:0] oe_mask);
      int c;
      c       = 0;
      we_mask = '0;
      oe_mask = '0;
      bus.wr_en      = wr;
      bus.rd_en      = rd;
      bus.address    = a;
      bus.write_data = d;
      #1;
      while (bus.ready !== 1'b1 && c < 15) begin
         if (bus.sram_we_n === 1'b0) we_mask[c] = 1'b1;
         if (bus.sram_dq_oe === 1'b1) oe_mask[c] = 1'b1;
         seen_addr[c] = bus.sram_addr;
         seen_dq[c]   = bus.sram_dq_out;
         tick();
         c++;
      end
      ncyc = c + 1;
      check_eq({tag, "_done_ready"}, 32'(bus.ready), 32'h1);
   endtask

   initial begin
      int          n1, n2, bad;
      logic [15:0] wm, om;

      rst            = 1'b1;
      bus.rd_en      = 1'b0;
      bus.wr_en      = 1'b0;
      bus.address    = '0;
      bus.write_data = '0;
      tick();
      tick();

      check_eq("rst_ready",     32'(bus.ready),       32'h1);
      check_eq("rst_read_data", bus.read_data,        32'h0);
      check_eq("rst_addr",      32'(bus.sram_addr),   32'h0);
      check_eq("rst_dq_out",    32'(bus.sram_dq_out), 32'h0);
      check_eq("rst_dq_oe",     32'(bus.sram_dq_oe),  32'h0);
      check_eq("rst_ctl_n",
               32'({bus.sram_we_n, bus.sram_oe_n, bus.sram_ce_n, bus.sram_ub_n, bus.sram_lb_n}),
               32'h1F);

      rst = 1'b0;
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (bus.ready !== 1'b1 || bus.sram_ce_n !== 1'b1) bad++;
      end
      check_eq("noop_ready_cycles_bad", 32'(bad), 32'h0);

      // Store 0xDEADBEEF to word 0.
      run_access("st0", 1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, n1, wm, om);
      check_eq("st0_cycles",  32'(n1),           32'd6);
      check_eq("st0_we_mask", 32'(wm),           32'h0000_000A);
      check_eq("st0_oe_mask", 32'(om),           32'h0000_001E);
      check_eq("st0_lo_addr", 32'(seen_addr[1]), 32'h0);
      check_eq("st0_hi_addr", 32'(seen_addr[3]), 32'h1);
      check_eq("st0_lo_dq",   32'(seen_dq[1]),   32'h0000_BEEF);
      check_eq("st0_hi_dq",   32'(seen_dq[3]),   32'h0000_DEAD);
      check_eq("st0_rdata",   bus.read_data,     32'h0);
      go_idle();
      check_eq("st0_mem0", 32'(u_sram.mem[0]), 32'h0000_BEEF);
      check_eq("st0_mem1", 32'(u_sram.mem[1]), 32'h0000_DEAD);

      // Load it back.
      run_access("ld0", 1'b0, 1'b1, 32'd1024, 32'h0, n1, wm, om);
      check_eq("ld0_cycles",  32'(n1),       32'd6);
      check_eq("ld0_oe_mask", 32'(om),       32'h0);
      check_eq("ld0_we_mask", 32'(wm),       32'h0);
      check_eq("ld0_rdata",   bus.read_data, 32'hDEADBEEF);
      go_idle();
      tick();
      tick();
      check_eq("ld0_rdata_hold", bus.read_data, 32'hDEADBEEF);

      // Back-to-back store then load at 1028 (word 1 -> half-words 2,3).
      run_access("b2b_st", 1'b1, 1'b0, 32'd1028, 32'h12345678, n1, wm, om);
      check_eq("b2b_st_lo_addr", 32'(seen_addr[1]), 32'h2);
      check_eq("b2b_st_hi_addr", 32'(seen_addr[3]), 32'h3);
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b1;
      tick();
      run_access("b2b_ld", 1'b0, 1'b1, 32'd1028, 32'h0, n2, wm, om);
      check_eq("b2b_total_cycles", 32'(n1 + n2),   32'd12);
      check_eq("b2b_rdata",        bus.read_data, 32'h12345678);
      go_idle();

      // rd_en and wr_en together behave as a store.
      run_access("both", 1'b1, 1'b1, 32'd1032, 32'hA5A55A5A, n1, wm, om);
      check_eq("both_we_mask", 32'(wm),       32'h0000_000A);
      check_eq("both_rdata",   bus.read_data, 32'h12345678);
      go_idle();
      check_eq("both_mem4", 32'(u_sram.mem[4]), 32'h0000_5A5A);
      check_eq("both_mem5", 32'(u_sram.mem[5]), 32'h0000_A5A5);
      run_access("both_ld", 1'b0, 1'b1, 32'd1032, 32'h0, n1, wm, om);
      check_eq("both_ld_rdata", bus.read_data, 32'hA5A55A5A);
      go_idle();

      // Reset during the second HI cycle of a load from 1024.
      bus.rd_en   = 1'b1;
      bus.address = 32'd1024;
      tick();
      tick();
      tick();
      tick();
      check_eq("abort_hi_addr",   32'(bus.sram_addr), 32'h1);
      check_eq("abort_partial",   bus.read_data,      32'hA5A5BEEF);
      rst       = 1'b1;
      bus.rd_en = 1'b0;
      tick();
      check_eq("abort_ready",     32'(bus.ready),     32'h1);
      check_eq("abort_read_data", bus.read_data,      32'h0);
      check_eq("abort_ce_n",      32'(bus.sram_ce_n), 32'h1);
      rst = 1'b0;
      tick();
      run_access("post_ld", 1'b0, 1'b1, 32'd1028, 32'h0, n1, wm, om);
      check_eq("post_ld_cycles", 32'(n1),       32'd6);
      check_eq("post_ld_rdata",  bus.read_data, 32'h12345678);
      go_idle();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1, "watchdog expired");
   end

endmodule
